// File: rtl/stage_cfg_pkg.sv
// rtl/stage_cfg_pkg.sv - shared types for the stage configuration scheduler
// Contents: scheduler state enum, target-stage field width, control beat layout.
package stage_cfg_pkg;

  // Scheduler states: IDLE passes traffic, BLOCK drains PHVs, XFER forwards the
  // matching control packet, GUARD holds traffic off while the table write settles.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLOCK = 2'd1,
    XFER  = 2'd2,
    GUARD = 2'd3
  } sched_state_e;

  // Width of the target-stage field carried in the first control beat.
  localparam int STG_ID_W = 4;

  // Layout of one control beat at the default bus widths. The FIFO stores the
  // same fields flattened as {tlast, tkeep, tuser, tdata}.
  typedef struct packed {
    logic [511:0] tdata;
    logic [127:0] tuser;
    logic [63:0]  tkeep;
    logic         tlast;
  } ctrl_beat_t;

endpackage

// File: rtl/ctrl_beat_fifo.sv
// rtl/ctrl_beat_fifo.sv - synchronous FIFO holding control beats
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/wdata_i write side;
//        pop_i read side; rdata_o head entry (valid combinationally when !empty_o);
//        full_o/empty_o status.
module ctrl_beat_fifo #(
  parameter int WIDTH = 705,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             wr_en;
  logic             rd_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign rd_en = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
  assign wr_en = push_i && (!full_o || rd_en);

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

endmodule

// File: rtl/stage_cfg_sched.sv
// rtl/stage_cfg_sched.sv - quiesce scheduler for table reconfiguration of one stage
// Ports: axis_clk/aresetn clock and async active-low reset;
//        phv_in/phv_in_valid/ready_out upstream PHV handshake;
//        phv_out/phv_out_valid/stage_ready_out PHV toward the stage;
//        stage_done_valid one PHV retired by the stage;
//        c_s_axis_* control ingress (no backpressure); c_m_axis_* control egress;
//        quiesced scheduler not idle; ctrl_overflow sticky control-beat drop.
module stage_cfg_sched
  import stage_cfg_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int PHV_LEN              = 1024,
  parameter int STAGE_ID             = 0,
  parameter int STG_ID_LSB           = 368,
  parameter int MAX_INFLIGHT         = 16,
  parameter int CTRL_FIFO_DEPTH      = 16,
  parameter int GUARD_CYCLES         = 4
) (
  input  logic                              axis_clk,
  input  logic                              aresetn,
  input  logic [PHV_LEN-1:0]                phv_in,
  input  logic                              phv_in_valid,
  output logic                              ready_out,
  output logic [PHV_LEN-1:0]                phv_out,
  output logic                              phv_out_valid,
  input  logic                              stage_ready_out,
  input  logic                              stage_done_valid,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
  input  logic                              c_s_axis_tvalid,
  input  logic                              c_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast,
  output logic                              quiesced,
  output logic                              ctrl_overflow
);

  localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
  localparam int BEAT_W = C_S_AXIS_DATA_WIDTH + C_S_AXIS_TUSER_WIDTH + KEEP_W + 1;
  localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1);
  localparam int GRD_W  = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  localparam logic [STG_ID_W-1:0] MY_STAGE = STG_ID_W'(STAGE_ID);
  localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [GRD_W-1:0]    GRD_LOAD = GRD_W'(GUARD_CYCLES - 1);
  localparam logic [GRD_W-1:0]    GRD_ONE  = GRD_W'(1);

  sched_state_e state_q;
  logic [CNT_W-1:0] inflight_q;
  logic [CNT_W-1:0] inflight_d;
  logic [GRD_W-1:0] guard_q;
  logic             at_sop_q;
  logic             overflow_q;

  logic [C_S_AXIS_DATA_WIDTH-1:0]  cm_tdata_q;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] cm_tuser_q;
  logic [KEEP_W-1:0]               cm_tkeep_q;
  logic                            cm_tvalid_q;
  logic                            cm_tlast_q;

  logic [BEAT_W-1:0]               head_beat;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  head_tdata;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] head_tuser;
  logic [KEEP_W-1:0]               head_tkeep;
  logic                            head_tlast;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic                            pop;
  logic                            head_match;
  logic                            admit;
  logic                            retire;

  ctrl_beat_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (CTRL_FIFO_DEPTH)
  ) u_ctrl_fifo (
    .clk_i   (axis_clk),
    .rst_ni  (aresetn),
    .push_i  (c_s_axis_tvalid),
    .wdata_i ({c_s_axis_tlast, c_s_axis_tkeep, c_s_axis_tuser, c_s_axis_tdata}),
    .pop_i   (pop),
    .rdata_o (head_beat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {head_tlast, head_tkeep, head_tuser, head_tdata} = head_beat;

  // Only the first beat of a packet carries the target-stage field; continuation
  // beats are never interpreted, whatever their payload happens to contain.
  assign head_match = !fifo_empty && at_sop_q &&
                      (head_tdata[STG_ID_LSB +: STG_ID_W] == MY_STAGE);

  // Admission is cut off combinationally in the very cycle a matching head shows
  // up, so no PHV slips in ahead of the reconfiguration. Held low through reset.
  assign admit = aresetn && (state_q == IDLE) && stage_ready_out &&
                 (inflight_q < CNT_MAX) && !head_match;

  assign ready_out     = admit;
  assign phv_out       = phv_in;
  assign phv_out_valid = phv_in_valid && admit;

  always_comb begin
    pop = 1'b0;
    case (state_q)
      IDLE:    pop = !fifo_empty && !head_match;
      XFER:    pop = !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // A retire reported while nothing is counted is ignored rather than wrapping.
  assign retire = stage_done_valid && (inflight_q != '0);

  always_comb begin
    inflight_d = inflight_q;
    if (phv_out_valid && !retire) begin
      inflight_d = inflight_q + CNT_ONE;
    end else if (!phv_out_valid && retire) begin
      inflight_d = inflight_q - CNT_ONE;
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      guard_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (head_match) state_q <= BLOCK;
        end
        BLOCK: begin
          // Uses the registered count, so the last retire is fully absorbed first.
          if (inflight_q == '0) state_q <= XFER;
        end
        XFER: begin
          if (pop && head_tlast) begin
            state_q <= GUARD;
            guard_q <= GRD_LOAD;
          end
        end
        GUARD: begin
          if (guard_q == '0) begin
            state_q <= IDLE;
          end else begin
            guard_q <= guard_q - GRD_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      at_sop_q <= 1'b1;
    end else if (pop) begin
      at_sop_q <= head_tlast;
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      overflow_q <= 1'b0;
    end else if (c_s_axis_tvalid && fifo_full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      cm_tvalid_q <= 1'b0;
      cm_tlast_q  <= 1'b0;
      cm_tdata_q  <= '0;
      cm_tuser_q  <= '0;
      cm_tkeep_q  <= '0;
    end else begin
      cm_tvalid_q <= pop;
      cm_tlast_q  <= pop && head_tlast;
      if (pop) begin
        cm_tdata_q <= head_tdata;
        cm_tuser_q <= head_tuser;
        cm_tkeep_q <= head_tkeep;
      end
    end
  end

  assign c_m_axis_tdata  = cm_tdata_q;
  assign c_m_axis_tuser  = cm_tuser_q;
  assign c_m_axis_tkeep  = cm_tkeep_q;
  assign c_m_axis_tvalid = cm_tvalid_q;
  assign c_m_axis_tlast  = cm_tlast_q;

  assign quiesced      = (state_q != IDLE);
  assign ctrl_overflow = overflow_q;

endmodule

// File: tb/tb_stage_cfg_sched.sv
// tb/tb_stage_cfg_sched.sv - directed self-checking bench for stage_cfg_sched
module tb_stage_cfg_sched;

  logic           axis_clk;
  logic           aresetn;
  logic [1023:0]  phv_in;
  logic           phv_in_valid;
  logic           ready_out;
  logic [1023:0]  phv_out;
  logic           phv_out_valid;
  logic           stage_ready_out;
  logic           stage_done_valid;
  logic [511:0]   c_s_axis_tdata;
  logic [127:0]   c_s_axis_tuser;
  logic [63:0]    c_s_axis_tkeep;
  logic           c_s_axis_tvalid;
  logic           c_s_axis_tlast;
  logic [511:0]   c_m_axis_tdata;
  logic [127:0]   c_m_axis_tuser;
  logic [63:0]    c_m_axis_tkeep;
  logic           c_m_axis_tvalid;
  logic           c_m_axis_tlast;
  logic           quiesced;
  logic           ctrl_overflow;

  int checks   = 0;
  int failures = 0;

  stage_cfg_sched dut (
    .axis_clk         (axis_clk),
    .aresetn          (aresetn),
    .phv_in           (phv_in),
    .phv_in_valid     (phv_in_valid),
    .ready_out        (ready_out),
    .phv_out          (phv_out),
    .phv_out_valid    (phv_out_valid),
    .stage_ready_out  (stage_ready_out),
    .stage_done_valid (stage_done_valid),
    .c_s_axis_tdata   (c_s_axis_tdata),
    .c_s_axis_tuser   (c_s_axis_tuser),
    .c_s_axis_tkeep   (c_s_axis_tkeep),
    .c_s_axis_tvalid  (c_s_axis_tvalid),
    .c_s_axis_tlast   (c_s_axis_tlast),
    .c_m_axis_tdata   (c_m_axis_tdata),
    .c_m_axis_tuser   (c_m_axis_tuser),
    .c_m_axis_tkeep   (c_m_axis_tkeep),
    .c_m_axis_tvalid  (c_m_axis_tvalid),
    .c_m_axis_tlast   (c_m_axis_tlast),
    .quiesced         (quiesced),
    .ctrl_overflow    (ctrl_overflow)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic set_beat(input logic [3:0] tgt, input logic [15:0] tag, input logic last);
    c_s_axis_tdata             = '0;
    c_s_axis_tdata[368 +: 4]   = tgt;
    c_s_axis_tdata[15:0]       = tag;
    c_s_axis_tuser             = {112'd0, tag};
    c_s_axis_tkeep             = '1;
    c_s_axis_tvalid            = 1'b1;
    c_s_axis_tlast             = last;
  endtask

  task automatic clr_beat();
    c_s_axis_tdata  = '0;
    c_s_axis_tuser  = '0;
    c_s_axis_tkeep  = '0;
    c_s_axis_tvalid = 1'b0;
    c_s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    phv_in_valid     = 1'b0;
    stage_done_valid = 1'b1;
    repeat (20) tick();
    stage_done_valid = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; phv_in_valid = 1'b1; stage_ready_out = 1'b1; stage_done_valid = 1'b0;
    phv_in = {16{64'hC0DE_0000_1234_5678}};
    clr_beat();
    repeat (3) tick();
    checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL rst_ready: got=%0b exp=0", ready_out); end
    checks++; if (phv_out_valid !== 1'b0) begin failures++; $display("FAIL rst_phv_valid: got=%0b exp=0", phv_out_valid); end
    checks++; if (c_m_axis_tvalid !== 1'b0 || c_m_axis_tlast !== 1'b0) begin failures++; $display("FAIL rst_cm_ctl: got=%0b%0b exp=00", c_m_axis_tvalid, c_m_axis_tlast); end
    checks++; if (c_m_axis_tdata !== 512'd0 || c_m_axis_tuser !== 128'd0 || c_m_axis_tkeep !== 64'd0) begin failures++; $display("FAIL rst_cm_data: got=%0h exp=0", c_m_axis_tdata[63:0]); end
    checks++; if (quiesced !== 1'b0 || ctrl_overflow !== 1'b0) begin failures++; $display("FAIL rst_status: got=%0b%0b exp=00", quiesced, ctrl_overflow); end
    checks++; if (phv_out !== phv_in) begin failures++; $display("FAIL phv_passthru: got=%0h exp=%0h", phv_out[63:0], phv_in[63:0]); end
    phv_in_valid = 1'b0;
    aresetn = 1'b1;
    #1;
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL post_rst_ready: got=%0b exp=1", ready_out); end
  endtask

  task automatic test_nonmatch();
    logic ev;
    stage_ready_out = 1'b1; phv_in_valid = 1'b1; stage_done_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) set_beat(4'd1, 16'hA0 + 16'(i), (i == 2)); else clr_beat();
      #1;
      checks++; if (ready_out !== 1'b1 || phv_out_valid !== 1'b1) begin failures++; $display("FAIL nm_ready[%0d]: got=%0b exp=1", i, ready_out); end
      ev = (i >= 2) && (i <= 4);
      checks++; if (c_m_axis_tvalid !== ev) begin failures++; $display("FAIL nm_tvalid[%0d]: got=%0b exp=%0b", i, c_m_axis_tvalid, ev); end
      if (ev) begin
        checks++;
        if (c_m_axis_tdata[15:0] !== 16'hA0 + 16'(i - 2) || c_m_axis_tuser[15:0] !== 16'hA0 + 16'(i - 2) || c_m_axis_tlast !== (i == 4)) begin
          failures++; $display("FAIL nm_beat[%0d]: got=%0h/%0b exp=%0h/%0b", i, c_m_axis_tdata[15:0], c_m_axis_tlast, 16'hA0 + 16'(i - 2), (i == 4));
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_match_inflight();
    logic er, ev, eq;
    stage_ready_out = 1'b1; stage_done_valid = 1'b0; phv_in_valid = 1'b1;
    tick(); tick();
    set_beat(4'd0, 16'hB0, 1'b0);
    tick();
    for (int c = 0; c <= 20; c++) begin
      if (c == 0) set_beat(4'd0, 16'hB1, 1'b1); else clr_beat();
      stage_done_valid = (c == 5) || (c == 9) || (c == 12);
      #1;
      er = (c == 20);
      checks++; if (ready_out !== er || phv_out_valid !== er) begin failures++; $display("FAIL mi_ready[%0d]: got=%0b/%0b exp=%0b", c, ready_out, phv_out_valid, er); end
      eq = (c >= 1) && (c <= 19);
      checks++; if (quiesced !== eq) begin failures++; $display("FAIL mi_quiesced[%0d]: got=%0b exp=%0b", c, quiesced, eq); end
      ev = (c == 15) || (c == 16);
      checks++; if (c_m_axis_tvalid !== ev) begin failures++; $display("FAIL mi_tvalid[%0d]: got=%0b exp=%0b", c, c_m_axis_tvalid, ev); end
      if (ev) begin
        checks++;
        if (c_m_axis_tdata[15:0] !== 16'hB0 + 16'(c - 15) || c_m_axis_tlast !== (c == 16)) begin
          failures++; $display("FAIL mi_beat[%0d]: got=%0h/%0b exp=%0h/%0b", c, c_m_axis_tdata[15:0], c_m_axis_tlast, 16'hB0 + 16'(c - 15), (c == 16));
        end
      end
      tick();
    end
    stage_done_valid = 1'b0;
    drain();
  endtask

  task automatic test_match_idle();
    logic er, ev;
    stage_ready_out = 1'b1; phv_in_valid = 1'b0; stage_done_valid = 1'b0;
    set_beat(4'd0, 16'hC0, 1'b1);
    tick();
    for (int c = 0; c <= 7; c++) begin
      clr_beat();
      #1;
      er = (c == 7);
      checks++; if (ready_out !== er) begin failures++; $display("FAIL mz_ready[%0d]: got=%0b exp=%0b", c, ready_out, er); end
      ev = (c == 3);
      checks++; if (c_m_axis_tvalid !== ev) begin failures++; $display("FAIL mz_tvalid[%0d]: got=%0b exp=%0b", c, c_m_axis_tvalid, ev); end
      tick();
    end
  endtask

  task automatic test_overflow();
    int nbeats;
    int nlast;
    logic [15:0] last_tag;
    stage_ready_out = 1'b1; stage_done_valid = 1'b0;
    phv_in_valid = 1'b1;
    tick();
    phv_in_valid = 1'b0;
    for (int b = 0; b <= 16; b++) begin
      set_beat((b == 0) ? 4'd0 : 4'd15, 16'hD00 + 16'(b), (b == 15));
      tick();
      checks++; if (ctrl_overflow !== (b == 16)) begin failures++; $display("FAIL ov_flag[%0d]: got=%0b exp=%0b", b, ctrl_overflow, (b == 16)); end
    end
    clr_beat();
    stage_done_valid = 1'b1;
    tick();
    stage_done_valid = 1'b0;
    nbeats = 0; nlast = 0; last_tag = '0;
    for (int n = 0; n < 40; n++) begin
      if (c_m_axis_tvalid) begin
        checks++; if (c_m_axis_tdata[15:0] !== 16'hD00 + 16'(nbeats)) begin failures++; $display("FAIL ov_order[%0d]: got=%0h exp=%0h", nbeats, c_m_axis_tdata[15:0], 16'hD00 + 16'(nbeats)); end
        last_tag = c_m_axis_tdata[15:0];
        if (c_m_axis_tlast) nlast++;
        nbeats++;
      end
      tick();
    end
    checks++; if (nbeats != 16) begin failures++; $display("FAIL ov_count: got=%0d exp=16", nbeats); end
    checks++; if (last_tag !== 16'hD0F || nlast != 1) begin failures++; $display("FAIL ov_last: got=%0h/%0d exp=d0f/1", last_tag, nlast); end
    checks++; if (quiesced !== 1'b0 || ctrl_overflow !== 1'b1) begin failures++; $display("FAIL ov_end: got=%0b%0b exp=01", quiesced, ctrl_overflow); end
  endtask

  task automatic test_max_inflight();
    stage_ready_out = 1'b1; stage_done_valid = 1'b0; phv_in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL mx_fill[%0d]: got=%0b exp=1", i, ready_out); end
      tick();
    end
    checks++; if (ready_out !== 1'b0 || phv_out_valid !== 1'b0) begin failures++; $display("FAIL mx_full: got=%0b/%0b exp=0", ready_out, phv_out_valid); end
    stage_done_valid = 1'b1;
    tick();
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL mx_retire: got=%0b exp=1", ready_out); end
    tick();
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL mx_both: got=%0b exp=1", ready_out); end
    stage_done_valid = 1'b0;
    tick();
    checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL mx_refill: got=%0b exp=0", ready_out); end
    drain();
  endtask

  task automatic test_reset_midxfer();
    stage_ready_out = 1'b1; stage_done_valid = 1'b0; phv_in_valid = 1'b0;
    checks++; if (ctrl_overflow !== 1'b1) begin failures++; $display("FAIL rx_sticky: got=%0b exp=1", ctrl_overflow); end
    set_beat(4'd0, 16'hE0, 1'b0);
    tick();
    for (int c = 0; c < 4; c++) begin
      set_beat(4'd15, 16'hE1 + 16'(c), 1'b0);
      #1;
      if (c == 3) begin
        checks++; if (c_m_axis_tvalid !== 1'b1 || c_m_axis_tdata[15:0] !== 16'hE0 || quiesced !== 1'b1) begin
          failures++; $display("FAIL rx_xfer: got=%0b/%0h/%0b exp=1/e0/1", c_m_axis_tvalid, c_m_axis_tdata[15:0], quiesced);
        end
      end
      tick();
    end
    clr_beat();
    phv_in_valid = 1'b1;
    aresetn = 1'b0;
    #1;
    checks++; if (c_m_axis_tvalid !== 1'b0 || c_m_axis_tlast !== 1'b0 || c_m_axis_tdata !== 512'd0) begin failures++; $display("FAIL rx_cm: got=%0b/%0h exp=0/0", c_m_axis_tvalid, c_m_axis_tdata[15:0]); end
    checks++; if (quiesced !== 1'b0 || ctrl_overflow !== 1'b0) begin failures++; $display("FAIL rx_status: got=%0b%0b exp=00", quiesced, ctrl_overflow); end
    checks++; if (ready_out !== 1'b0 || phv_out_valid !== 1'b0) begin failures++; $display("FAIL rx_ready: got=%0b/%0b exp=0", ready_out, phv_out_valid); end
    tick(); tick();
    phv_in_valid = 1'b0;
    aresetn = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++; if (c_m_axis_tvalid !== 1'b0 || ready_out !== 1'b1 || quiesced !== 1'b0) begin
        failures++; $display("FAIL rx_flushed[%0d]: got=%0b/%0b/%0b exp=0/1/0", n, c_m_axis_tvalid, ready_out, quiesced);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nonmatch();
    test_match_inflight();
    test_match_idle();
    test_overflow();
    test_max_inflight();
    test_reset_midxfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
